// File: rtl/chi_link_tx.sv
// CHI link-layer transmitter: NUM_CH credit-managed TX channels behind one shared link-activation FSM.
// Optional credit-stall performance counters are built when CHI_LINK_TX_PERF_EN is defined.
module chi_link_tx #(
    parameter int NUM_CH  = 4,
    parameter int FLIT_W  = 128,
    parameter int MAX_CRD = 15,
    localparam int CW     = $clog2(MAX_CRD + 1)
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     link_en,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    input  logic [NUM_CH*FLIT_W-1:0] in_flit,
    output logic [NUM_CH-1:0]        flitpend,
    output logic [NUM_CH-1:0]        flitv,
    output logic [NUM_CH*FLIT_W-1:0] flit,
    input  logic [NUM_CH-1:0]        lcrdv,
    output logic                     txlinkactivereq,
    input  logic                     txlinkactiveack,
    output logic [1:0]               link_state,
    output logic [NUM_CH*CW-1:0]     credit_cnt,
    output logic [NUM_CH-1:0]        crd_err,
    output logic [NUM_CH*32-1:0]     perf_stall_cnt
);

    typedef enum logic [1:0] {
        ST_STOP   = 2'd0,
        ST_ACT    = 2'd1,
        ST_RUN    = 2'd2,
        ST_DEACT  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic                  req_q, req_d;
    logic                  pend_q, pend_d;
    logic [NUM_CH-1:0]     flitv_q, flitv_d;
    logic [NUM_CH-1:0]     err_q, err_d;
    logic [FLIT_W-1:0]     flit_q   [NUM_CH];
    logic [FLIT_W-1:0]     flit_d   [NUM_CH];
    logic [CW-1:0]         credit_q [NUM_CH];
    logic [CW-1:0]         credit_d [NUM_CH];
    logic [NUM_CH-1:0]     in_ready_s;
    logic [NUM_CH-1:0]     send_s;
    logic [NUM_CH-1:0]     ret_s;
    logic [NUM_CH-1:0]     inc_s;

    // Link-activation next state; link_en is only sampled in the stable states.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP:  if (link_en)          state_d = ST_ACT;   else state_d = ST_STOP;
            ST_ACT:   if (txlinkactiveack)  state_d = ST_RUN;   else state_d = ST_ACT;
            ST_RUN:   if (!link_en)         state_d = ST_DEACT; else state_d = ST_RUN;
            ST_DEACT: if (!txlinkactiveack) state_d = ST_STOP;  else state_d = ST_DEACT;
            default:                        state_d = ST_STOP;
        endcase
        req_d  = (state_d == ST_ACT) || (state_d == ST_RUN);
        pend_d = (state_d != ST_STOP);
    end

    // Per-channel send decision, credit accounting and flit capture.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            in_ready_s[c] = (state_q == ST_RUN) && (credit_q[c] != '0);
            ret_s[c]      = (state_q == ST_DEACT) && (credit_q[c] != '0);
            send_s[c]     = (in_valid[c] && in_ready_s[c]) || ret_s[c];
            inc_s[c]      = lcrdv[c] && (state_q != ST_STOP);
            credit_d[c]   = credit_q[c];
            err_d[c]      = err_q[c];
            flit_d[c]     = flit_q[c];
            flitv_d[c]    = send_s[c];

            if (lcrdv[c] && (state_q == ST_STOP)) begin
                err_d[c] = 1'b1;
            end else if (inc_s[c] && !send_s[c]) begin
                // Receiver over-granted: hold at the ceiling and flag it.
                if (credit_q[c] == CW'(MAX_CRD)) begin
                    err_d[c] = 1'b1;
                end else begin
                    credit_d[c] = credit_q[c] + CW'(1);
                end
            end else if (send_s[c] && !inc_s[c]) begin
                credit_d[c] = credit_q[c] - CW'(1);
            end else begin
                credit_d[c] = credit_q[c];
            end

            if (ret_s[c]) begin
                flit_d[c] = {FLIT_W{1'b0}};
            end else if (send_s[c]) begin
                flit_d[c] = in_flit[c*FLIT_W +: FLIT_W];
            end else begin
                flit_d[c] = flit_q[c];
            end
        end
    end

    // State, link control and per-channel registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_STOP;
            req_q   <= 1'b0;
            pend_q  <= 1'b0;
            flitv_q <= '0;
            err_q   <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                flit_q[c]   <= {FLIT_W{1'b0}};
                credit_q[c] <= {CW{1'b0}};
            end
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            pend_q  <= pend_d;
            flitv_q <= flitv_d;
            err_q   <= err_d;
            for (int c = 0; c < NUM_CH; c++) begin
                flit_q[c]   <= flit_d[c];
                credit_q[c] <= credit_d[c];
            end
        end
    end

    assign in_ready        = in_ready_s;
    assign flitv           = flitv_q;
    assign flitpend        = {NUM_CH{pend_q}};
    assign txlinkactivereq = req_q;
    assign link_state      = state_q;
    assign crd_err         = err_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign flit[g*FLIT_W +: FLIT_W] = flit_q[g];
        assign credit_cnt[g*CW +: CW]   = credit_q[g];
    end

`ifdef CHI_LINK_TX_PERF_EN
    logic [31:0] perf_q [NUM_CH];
    logic [31:0] perf_d [NUM_CH];

    // Count RUN cycles where a channel has a flit but no credit, saturating.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            if ((state_q == ST_RUN) && in_valid[c] && (credit_q[c] == '0)
                && (perf_q[c] != 32'hFFFF_FFFF)) begin
                perf_d[c] = perf_q[c] + 32'd1;
            end else begin
                perf_d[c] = perf_q[c];
            end
        end
    end

    // Stall counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int c = 0; c < NUM_CH; c++) perf_q[c] <= 32'd0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) perf_q[c] <= perf_d[c];
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_perf
        assign perf_stall_cnt[g*32 +: 32] = perf_q[g];
    end
`else
    assign perf_stall_cnt = {(NUM_CH*32){1'b0}};
`endif

endmodule

// File: tb/tb_chi_link_tx.sv
// Table-driven bench for chi_link_tx with a flit scoreboard checked on the falling edge.
module tb_chi_link_tx;

    localparam int NC = 4;
    localparam int FW = 16;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            resetn;
    logic            link_en;
    logic [NC-1:0]   in_valid;
    logic [NC-1:0]   in_ready;
    logic [NC*FW-1:0] in_flit;
    logic [NC-1:0]   flitpend;
    logic [NC-1:0]   flitv;
    logic [NC*FW-1:0] flit;
    logic [NC-1:0]   lcrdv;
    logic            txlinkactivereq;
    logic            txlinkactiveack;
    logic [1:0]      link_state;
    logic [NC*CW-1:0] credit_cnt;
    logic [NC-1:0]   crd_err;
    logic [NC*32-1:0] perf_stall_cnt;

    chi_link_tx #(.NUM_CH(NC), .FLIT_W(FW), .MAX_CRD(15)) dut (
        .clk(clk), .resetn(resetn), .link_en(link_en),
        .in_valid(in_valid), .in_ready(in_ready), .in_flit(in_flit),
        .flitpend(flitpend), .flitv(flitv), .flit(flit), .lcrdv(lcrdv),
        .txlinkactivereq(txlinkactivereq), .txlinkactiveack(txlinkactiveack),
        .link_state(link_state), .credit_cnt(credit_cnt), .crd_err(crd_err),
        .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        le;
        logic        ack;
        logic [3:0]  lcrd;
        logic [3:0]  vld;
        logic [15:0] fl;
        logic [3:0]  rdy;
        logic [3:0]  ret;
        logic [1:0]  st;
        logic [15:0] crd;
        logic [3:0]  err;
        logic        req;
        logic        pend;
    } vec_t;

    typedef struct {
        int          ch;
        logic [15:0] d;
    } sb_t;

    sb_t  sbq[$];
    vec_t tbl[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic le, input logic ack, input logic [3:0] lcrd,
                                input logic [3:0] vld, input logic [15:0] fl,
                                input logic [3:0] rdy, input logic [3:0] ret,
                                input logic [1:0] st, input logic [15:0] crd,
                                input logic [3:0] err, input logic req, input logic pend);
        vec_t v;
        v.le = le; v.ack = ack; v.lcrd = lcrd; v.vld = vld; v.fl = fl;
        v.rdy = rdy; v.ret = ret; v.st = st; v.crd = crd; v.err = err;
        v.req = req; v.pend = pend;
        return v;
    endfunction

    // Drive one cycle of inputs, push expected flits, then check registered outputs.
    task automatic apply(input vec_t v);
        sb_t e;
        link_en         = v.le;
        txlinkactiveack = v.ack;
        lcrdv           = v.lcrd;
        in_valid        = v.vld;
        in_flit         = {NC{v.fl}};
        #1;
        chk("in_ready", 64'(in_ready), 64'(v.rdy));
        for (int c = 0; c < NC; c++) begin
            if (v.rdy[c] && v.vld[c]) begin
                e.ch = c; e.d = v.fl; sbq.push_back(e);
            end
            if (v.ret[c]) begin
                e.ch = c; e.d = 16'h0000; sbq.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        chk("link_state", 64'(link_state), 64'(v.st));
        chk("credit_cnt", 64'(credit_cnt), 64'(v.crd));
        chk("crd_err", 64'(crd_err), 64'(v.err));
        chk("txlinkactivereq", 64'(txlinkactivereq), 64'(v.req));
        chk("flitpend", 64'(flitpend), 64'(v.pend ? 4'hF : 4'h0));
    endtask

    // Scoreboard: every flitv beat must match the oldest expected flit in channel order.
    always @(negedge clk) begin
        if (resetn) begin
            for (int c = 0; c < NC; c++) begin
                if (flitv[c]) begin
                    if (sbq.size() == 0) begin
                        chk("sb_unexpected_flit_ch", 64'(c), 64'hFFFF);
                    end else begin
                        sb_t e;
                        e = sbq.pop_front();
                        chk("sb_channel", 64'(c), 64'(e.ch));
                        chk("sb_flit", 64'(flit[c*FW +: FW]), 64'(e.d));
                    end
                end
            end
        end
    end

    initial begin
        logic [31:0] exp_perf;
`ifdef CHI_LINK_TX_PERF_EN
        exp_perf = 32'd5;
`else
        exp_perf = 32'd0;
`endif
        resetn = 1'b0; link_en = 1'b0; txlinkactiveack = 1'b0;
        lcrdv = '0; in_valid = '0; in_flit = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 64'(link_state), 64'd0);
        chk("rst_req", 64'(txlinkactivereq), 64'd0);
        chk("rst_pend", 64'(flitpend), 64'd0);
        chk("rst_flitv", 64'(flitv), 64'd0);
        chk("rst_flit", flit, 64'd0);
        chk("rst_credit", 64'(credit_cnt), 64'd0);
        chk("rst_err", 64'(crd_err), 64'd0);
        chk("rst_perf", 64'(perf_stall_cnt[127:64] | perf_stall_cnt[63:0]), 64'd0);
        resetn = 1'b1;

        // Activation, credit/send on ch1, simultaneous grant+send.
        tbl.push_back(mk(1, 0, 4'h0, 4'h0, 16'h0, 4'h0, 4'h0, 2'd1, 16'h0000, 4'h0, 1, 1));
        tbl.push_back(mk(1, 0, 4'h0, 4'h0, 16'h0, 4'h0, 4'h0, 2'd1, 16'h0000, 4'h0, 1, 1));
        tbl.push_back(mk(1, 0, 4'h0, 4'h0, 16'h0, 4'h0, 4'h0, 2'd1, 16'h0000, 4'h0, 1, 1));
        tbl.push_back(mk(1, 1, 4'h0, 4'h0, 16'h0, 4'h0, 4'h0, 2'd2, 16'h0000, 4'h0, 1, 1));
        tbl.push_back(mk(1, 1, 4'h2, 4'h0, 16'h0, 4'h0, 4'h0, 2'd2, 16'h0010, 4'h0, 1, 1));
        tbl.push_back(mk(1, 1, 4'h2, 4'h0, 16'h0, 4'h2, 4'h0, 2'd2, 16'h0020, 4'h0, 1, 1));
        tbl.push_back(mk(1, 1, 4'h0, 4'h2, 16'hA, 4'h2, 4'h0, 2'd2, 16'h0010, 4'h0, 1, 1));
        tbl.push_back(mk(1, 1, 4'h0, 4'h2, 16'hB, 4'h2, 4'h0, 2'd2, 16'h0000, 4'h0, 1, 1));
        tbl.push_back(mk(1, 1, 4'h0, 4'h2, 16'hC, 4'h0, 4'h0, 2'd2, 16'h0000, 4'h0, 1, 1));
        tbl.push_back(mk(1, 1, 4'h2, 4'h2, 16'hC, 4'h0, 4'h0, 2'd2, 16'h0010, 4'h0, 1, 1));
        tbl.push_back(mk(1, 1, 4'h0, 4'h2, 16'hC, 4'h2, 4'h0, 2'd2, 16'h0000, 4'h0, 1, 1));
        tbl.push_back(mk(1, 1, 4'h2, 4'h0, 16'h0, 4'h0, 4'h0, 2'd2, 16'h0010, 4'h0, 1, 1));
        tbl.push_back(mk(1, 1, 4'h2, 4'h2, 16'hD, 4'h2, 4'h0, 2'd2, 16'h0010, 4'h0, 1, 1));
        tbl.push_back(mk(1, 1, 4'h0, 4'h2, 16'hE, 4'h2, 4'h0, 2'd2, 16'h0000, 4'h0, 1, 1));
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i]);

        // Overflow: 16 grants on idle ch0 saturate at 15 and flag an error.
        for (int i = 1; i <= 16; i++)
            apply(mk(1, 1, 4'h1, 4'h0, 16'h0, (i == 1) ? 4'h0 : 4'h1, 4'h0, 2'd2,
                     16'((i > 15) ? 15 : i), (i == 16) ? 4'h1 : 4'h0, 1, 1));
        // Drain ch0 down to 3 credits, then give ch2 one credit.
        for (int i = 1; i <= 12; i++)
            apply(mk(1, 1, 4'h0, 4'h1, 16'(16'h0100 + i), 4'h1, 4'h0, 2'd2,
                     16'(15 - i), 4'h1, 1, 1));
        apply(mk(1, 1, 4'h4, 4'h0, 16'h0, 4'h1, 4'h0, 2'd2, 16'h0103, 4'h1, 1, 1));

        // Deactivation with credit return; link_en glitch in DEACTIVATE ignored.
        apply(mk(0, 1, 4'h0, 4'h0, 16'h0, 4'h5, 4'h0, 2'd3, 16'h0103, 4'h1, 0, 1));
        apply(mk(0, 1, 4'h0, 4'h1, 16'h9, 4'h0, 4'h5, 2'd3, 16'h0002, 4'h1, 0, 1));
        apply(mk(0, 1, 4'h0, 4'h0, 16'h0, 4'h0, 4'h1, 2'd3, 16'h0001, 4'h1, 0, 1));
        apply(mk(1, 1, 4'h0, 4'h0, 16'h0, 4'h0, 4'h1, 2'd3, 16'h0000, 4'h1, 0, 1));
        apply(mk(0, 0, 4'h0, 4'h0, 16'h0, 4'h0, 4'h0, 2'd0, 16'h0000, 4'h1, 0, 0));
        apply(mk(0, 0, 4'h8, 4'h0, 16'h0, 4'h0, 4'h0, 2'd0, 16'h0000, 4'h9, 0, 0));

        // Reset in the middle of a transfer.
        apply(mk(1, 0, 4'h0, 4'h0, 16'h0, 4'h0, 4'h0, 2'd1, 16'h0000, 4'h9, 1, 1));
        apply(mk(1, 1, 4'h0, 4'h0, 16'h0, 4'h0, 4'h0, 2'd2, 16'h0000, 4'h9, 1, 1));
        apply(mk(1, 1, 4'h4, 4'h0, 16'h0, 4'h0, 4'h0, 2'd2, 16'h0100, 4'h9, 1, 1));
        apply(mk(1, 1, 4'h0, 4'h4, 16'h55, 4'h4, 4'h0, 2'd2, 16'h0000, 4'h9, 1, 1));
        chk("pre_rst_flitv", 64'(flitv), 64'h4);
        #2;
        resetn = 1'b0;
        #1;
        chk("mid_rst_flitv", 64'(flitv), 64'd0);
        chk("mid_rst_flit", flit, 64'd0);
        chk("mid_rst_state", 64'(link_state), 64'd0);
        chk("mid_rst_req", 64'(txlinkactivereq), 64'd0);
        chk("mid_rst_pend", 64'(flitpend), 64'd0);
        chk("mid_rst_err", 64'(crd_err), 64'd0);
        sbq.delete();
        link_en = 1'b0; txlinkactiveack = 1'b0; in_valid = '0; lcrdv = '0;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;

        // Five credit-starved RUN cycles on ch3.
        apply(mk(1, 0, 4'h0, 4'h0, 16'h0, 4'h0, 4'h0, 2'd1, 16'h0000, 4'h0, 1, 1));
        apply(mk(1, 1, 4'h0, 4'h0, 16'h0, 4'h0, 4'h0, 2'd2, 16'h0000, 4'h0, 1, 1));
        for (int i = 0; i < 5; i++)
            apply(mk(1, 1, 4'h0, 4'h8, 16'h77, 4'h0, 4'h0, 2'd2, 16'h0000, 4'h0, 1, 1));
        apply(mk(1, 1, 4'h0, 4'h0, 16'h0, 4'h0, 4'h0, 2'd2, 16'h0000, 4'h0, 1, 1));
        chk("perf_stall_ch3", 64'(perf_stall_cnt[3*32 +: 32]), 64'(exp_perf));
        chk("perf_stall_ch0", 64'(perf_stall_cnt[31:0]), 64'd0);

        @(negedge clk);
        #1;
        chk("sb_leftover", 64'(sbq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
